reg_file_param: RTL
===================

// Module: reg_file_param
// PURPOSE
//   Parametrised CPU integer register file: NUM_RD combinational read ports, one write port.
//   Optional hard-wired zero register and write-to-read bypass.
//   Two fixed tap outputs (ecall service / argument regs).
//   Debug inspection port with a small FSM: single capture on button edge, or auto-scan of all registers.
//   Sits between decode (read addrs) and writeback (write port); debug side drives the board display.
// PARAMETERS
//   DATA_W    32  register width in bits
//   ADDR_W    5   address width; DEPTH = 1<<ADDR_W registers
//   NUM_RD    2   number of read ports
//   ZERO_REG  1   1: reg 0 reads 0 and ignores writes; 0: reg 0 is an ordinary register
//   BYPASS    1   1: a read of the address being written this cycle returns wdata
//   TAP0_IDX  17  register index driven on tap0_data (a7)
//   TAP1_IDX  10  register index driven on tap1_data (a0)
//   SCAN_DIV  4   clk cycles per register step in SCAN state (>=1)
// PORTS
//   clk        in   1                clock, all state on rising edge
//   rstn       in   1                reset, asynchronous, active-low
//   raddr      in   NUM_RD*ADDR_W    packed read addresses; port k = raddr[k*ADDR_W +: ADDR_W]
//   rdata      out  NUM_RD*DATA_W    packed read data, same packing
//   we         in   1                write enable
//   waddr      in   ADDR_W           write address
//   wdata      in   DATA_W           write data
//   tap0_data  out  DATA_W           registers[TAP0_IDX], no bypass
//   tap1_data  out  DATA_W           registers[TAP1_IDX], no bypass
//   dbg_mode   in   1                debug enable
//   dbg_btn    in   1                capture button, debounced and synchronised upstream
//   dbg_scan   in   1                request auto-scan
//   dbg_sel    in   ADDR_W           register to capture
//   dbg_data   out  DATA_W           debug value (registered)
//   dbg_idx    out  ADDR_W           index of value on dbg_data (registered)
//   dbg_valid  out  1                dbg_data holds a captured/scanned value
// BEHAVIOUR
//   Reset (rstn=0, async): all registers, dbg_data, dbg_idx = 0; dbg_valid = 0; btn_q = 0; state = IDLE.
//     Reset mid-scan aborts immediately.
//   Write: at posedge, if we and !(ZERO_REG && waddr==0), registers[waddr] <= wdata; visible next cycle.
//   Read: combinational.
//     ZERO_REG && addr==0 -> 0.
//     Else if BYPASS && we && addr==waddr -> wdata.
//     Else registers[addr].
//     All ports are independent; identical addresses are legal.
//   Edge detect: btn_q <= dbg_btn each cycle; edge = dbg_btn & ~btn_q. Holding the button gives one edge.
//   FSM states: IDLE, HOLD, SCAN. dbg_mode=0 in any state -> next posedge: IDLE, dbg_data=0, dbg_valid=0.
//   IDLE:
//     edge -> dbg_data<=reg[dbg_sel], dbg_idx<=dbg_sel, dbg_valid<=1, go HOLD.
//     Else if dbg_scan -> SCAN entry.
//   HOLD:
//     Outputs frozen.
//     edge -> recapture as in IDLE.
//     dbg_scan=1 (no edge) -> SCAN entry.
//     Edge has priority over dbg_scan.
//   SCAN entry: dbg_data<=reg[0], dbg_idx<=0, div_cnt<=0, dbg_valid<=1.
//   SCAN:
//     div_cnt counts 0..SCAN_DIV-1.
//     At SCAN_DIV-1: idx<=idx+1 (wraps DEPTH-1 -> 0), dbg_data<=reg[idx+1], div_cnt<=0.
//     dbg_scan=0 -> HOLD, keeping the last value. Edges are ignored in SCAN.
//   Capture/scan reads raw storage (no bypass). A same-cycle write to the same index yields the OLD value.
//   ZERO_REG=1: debug read of index 0 returns 0.
// TESTING
//   1. Reset, write x5=0xDEADBEEF; next cycle raddr0=5 -> rdata0=0xDEADBEEF.
//      rdata1 (raddr1=0) = 0.
//   2. ZERO_REG=1: we=1, waddr=0, wdata=0x1234 -> reg0 reads 0.
//      Same write with ZERO_REG=0 -> next cycle reads 0x1234.
//   3. BYPASS=1: we=1, waddr=7, wdata=0x55, raddr0=7 same cycle -> rdata0=0x55.
//      Repeat with BYPASS=0 -> old value.
//   4. Write x17=0x5D, x10=0x2A -> tap0_data=0x5D, tap1_data=0x2A.
//   5. dbg_mode=1, dbg_sel=5, btn held 10 cycles -> one capture.
//      dbg_data=0xDEADBEEF, dbg_idx=5, dbg_valid=1.
//      Same-cycle write x5 at capture -> old value.
//   6. SCAN_DIV=4, ADDR_W=2:
//      dbg_scan=1 -> dbg_idx 0,1,2,3,0 each 4 cycles.
//      Drop dbg_scan -> HOLD keeps value.
//      Drop dbg_mode -> dbg_data=0, dbg_valid=0.
//      rstn low mid-scan -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/reg_file_param.sv
// reg_file_param: parametrised register file with bypass, zero register, taps and debug capture/scan port.
// Decode drives raddr, writeback drives the write port, and the debug side feeds the board display.
module reg_file_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1,
  parameter int TAP0_IDX = 17,
  parameter int TAP1_IDX = 10,
  parameter int SCAN_DIV = 4
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic [NUM_RD*ADDR_W-1:0] raddr,
  output logic [NUM_RD*DATA_W-1:0] rdata,
  input  logic                     we,
  input  logic [ADDR_W-1:0]        waddr,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        tap0_data,
  output logic [DATA_W-1:0]        tap1_data,
  input  logic                     dbg_mode,
  input  logic                     dbg_btn,
  input  logic                     dbg_scan,
  input  logic [ADDR_W-1:0]        dbg_sel,
  output logic [DATA_W-1:0]        dbg_data,
  output logic [ADDR_W-1:0]        dbg_idx,
  output logic                     dbg_valid
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam int CW = SCAN_DIV > 1 ? $clog2(SCAN_DIV) : 1;
  localparam logic [ADDR_W-1:0] T0 = ADDR_W'(TAP0_IDX);
  localparam logic [ADDR_W-1:0] T1 = ADDR_W'(TAP1_IDX);
  localparam logic [CW-1:0] DIV_LAST = CW'(SCAN_DIV - 1);
  typedef enum logic [1:0] {IDLE, HOLD, SCAN} state_t;
  logic [DATA_W-1:0] regs [DEPTH];
  state_t state, state_n;
  logic btn_q, btn_edge;
  logic [CW-1:0] div_cnt, div_cnt_n;
  logic [DATA_W-1:0] dbg_data_n, sel_val, nxt_val, zero_val;
  logic [ADDR_W-1:0] dbg_idx_n, nxt_idx;
  logic dbg_valid_n;
  always_ff @(posedge clk or negedge rstn)
    if (!rstn)
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    else if (we && !(ZERO_REG != 0 && waddr == '0))
      regs[waddr] <= wdata;
  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_W-1:0] a;
    assign a = raddr[k*ADDR_W +: ADDR_W];
    assign rdata[k*DATA_W +: DATA_W] = (ZERO_REG != 0 && a == '0) ? '0 :
                                       (BYPASS != 0 && we && a == waddr) ? wdata : regs[a];
  end
  assign tap0_data = regs[T0];
  assign tap1_data = regs[T1];
  // Debug reads see raw storage only, so a same-cycle write shows the old value.
  assign btn_edge = dbg_btn & ~btn_q;
  assign nxt_idx  = dbg_idx + 1'b1;
  assign sel_val  = (ZERO_REG != 0 && dbg_sel == '0) ? '0 : regs[dbg_sel];
  assign nxt_val  = (ZERO_REG != 0 && nxt_idx == '0) ? '0 : regs[nxt_idx];
  assign zero_val = ZERO_REG != 0 ? '0 : regs[0];
  always_comb begin
    state_n     = state;
    dbg_data_n  = dbg_data;
    dbg_idx_n   = dbg_idx;
    dbg_valid_n = dbg_valid;
    div_cnt_n   = div_cnt;
    if (!dbg_mode) begin
      state_n     = IDLE;
      dbg_data_n  = '0;
      dbg_valid_n = 1'b0;
    end else if (state != SCAN && btn_edge) begin
      state_n     = HOLD;
      dbg_data_n  = sel_val;
      dbg_idx_n   = dbg_sel;
      dbg_valid_n = 1'b1;
    end else if (state != SCAN && dbg_scan) begin
      state_n     = SCAN;
      dbg_data_n  = zero_val;
      dbg_idx_n   = '0;
      dbg_valid_n = 1'b1;
      div_cnt_n   = '0;
    end else if (state == SCAN && !dbg_scan) begin
      state_n = HOLD;
    end else if (state == SCAN) begin
      div_cnt_n  = div_cnt == DIV_LAST ? '0 : div_cnt + 1'b1;
      dbg_idx_n  = div_cnt == DIV_LAST ? nxt_idx : dbg_idx;
      dbg_data_n = div_cnt == DIV_LAST ? nxt_val : dbg_data;
    end
  end
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      state     <= IDLE;
      btn_q     <= 1'b0;
      div_cnt   <= '0;
      dbg_data  <= '0;
      dbg_idx   <= '0;
      dbg_valid <= 1'b0;
    end else begin
      state     <= state_n;
      btn_q     <= dbg_btn;
      div_cnt   <= div_cnt_n;
      dbg_data  <= dbg_data_n;
      dbg_idx   <= dbg_idx_n;
      dbg_valid <= dbg_valid_n;
    end
endmodule
